// File: rtl/decode_issue_queue_if.sv
// decode_issue_queue_if: fetch/execute handshake bundle for decode_issue_queue.
//   in_*     : fetch side (valid/ready push of instruction word and PC)
//   out_*    : execute side (valid/ready pop of head entry with decoded fields)
//   flush    : redirect, discards queued entries and any same-cycle push
// modport slave is the queue itself; modport master is the fetch/execute side.
interface decode_issue_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic        out_illegal;
  logic        flush;

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready, flush,
    output in_ready, out_valid, out_inst, out_pc, out_imm, out_fmt, out_illegal
  );

  modport master (
    output in_valid, in_inst, in_pc, out_ready, flush,
    input  in_ready, out_valid, out_inst, out_pc, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/decode_issue_queue.sv
// decode_issue_queue: two-entry FIFO between fetch and execute in the RV32I
// core. Each accepted instruction is classified and its sign-extended
// immediate generated at push time, so execute sees decoded fields straight
// from registers.
// Ports:
//   clk  : core clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : decode_issue_queue_if.slave (push side in_*, pop side out_*, flush)
module decode_issue_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input logic                  clk,
  input logic                  rst,
  decode_issue_queue_if.slave  bus
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  // Returns {fmt[2:0], illegal, imm[31:0]} for one instruction word.
  function automatic logic [35:0] decode(input logic [31:0] inst);
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] imm;
    fmt = FMT_ILL;
    ill = 1'b1;
    imm = 32'd0;
    case (inst[6:0])
      7'h03, 7'h0F, 7'h13, 7'h67, 7'h73: begin
        fmt = FMT_I;
        ill = 1'b0;
        imm = {{20{inst[31]}}, inst[31:20]};
      end
      7'h23: begin
        fmt = FMT_S;
        ill = 1'b0;
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      7'h63: begin
        fmt = FMT_B;
        ill = 1'b0;
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      7'h17, 7'h37: begin
        fmt = FMT_U;
        ill = 1'b0;
        imm = {inst[31:12], 12'd0};
      end
      7'h6F: begin
        fmt = FMT_J;
        ill = 1'b0;
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      7'h33: begin
        fmt = FMT_R;
        ill = 1'b0;
        imm = 32'd0;
      end
      default: begin
        // Unknown opcodes (including RV64 OP-IMM-32) are still queued.
        fmt = FMT_ILL;
        ill = 1'b1;
        imm = 32'd0;
      end
    endcase
    return {fmt, ill, imm};
  endfunction

  logic [1:0]      state_r;
  logic [1:0]      state_next_s;
  logic            wr_ptr_r;
  logic            rd_ptr_r;
  logic [XLEN-1:0] inst_r [DEPTH];
  logic [XLEN-1:0] pc_r   [DEPTH];
  logic [XLEN-1:0] imm_r  [DEPTH];
  logic [2:0]      fmt_r  [DEPTH];
  logic            ill_r  [DEPTH];

  logic            in_ready_s;
  logic            out_valid_s;
  logic            push_s;
  logic            pop_s;
  logic [35:0]     dec_s;

  // in_ready depends only on registered state so it never waits on out_ready.
  assign in_ready_s  = (state_r != ST_TWO) & ~rst;
  assign out_valid_s = (state_r != ST_EMPTY);
  assign push_s      = bus.in_valid & in_ready_s;
  assign pop_s       = out_valid_s & bus.out_ready;
  assign dec_s       = decode(bus.in_inst);

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_s;
  assign bus.out_inst    = inst_r[rd_ptr_r];
  assign bus.out_pc      = pc_r[rd_ptr_r];
  assign bus.out_imm     = imm_r[rd_ptr_r];
  assign bus.out_fmt     = fmt_r[rd_ptr_r];
  assign bus.out_illegal = ill_r[rd_ptr_r];

  // Occupancy next-state; flush overrides push and pop.
  always_comb begin
    state_next_s = state_r;
    if (bus.flush) begin
      state_next_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: state_next_s = push_s ? ST_ONE : ST_EMPTY;
        ST_ONE: begin
          if (push_s && !pop_s) begin
            state_next_s = ST_TWO;
          end else if (!push_s && pop_s) begin
            state_next_s = ST_EMPTY;
          end else begin
            state_next_s = ST_ONE;
          end
        end
        ST_TWO:   state_next_s = pop_s ? ST_ONE : ST_TWO;
        default:  state_next_s = ST_EMPTY;
      endcase
    end
  end

  // State and ring pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_EMPTY;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
    end else if (bus.flush) begin
      state_r  <= ST_EMPTY;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      wr_ptr_r <= wr_ptr_r ^ push_s;
      rd_ptr_r <= rd_ptr_r ^ pop_s;
    end
  end

  // Entry storage; cleared on reset so the head fields read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_r[i] <= '0;
        pc_r[i]   <= '0;
        imm_r[i]  <= '0;
        fmt_r[i]  <= 3'd0;
        ill_r[i]  <= 1'b0;
      end
    end else if (push_s && !bus.flush) begin
      inst_r[wr_ptr_r] <= bus.in_inst;
      pc_r[wr_ptr_r]   <= bus.in_pc;
      imm_r[wr_ptr_r]  <= dec_s[31:0];
      fmt_r[wr_ptr_r]  <= dec_s[35:33];
      ill_r[wr_ptr_r]  <= dec_s[32];
    end else begin
      inst_r[wr_ptr_r] <= inst_r[wr_ptr_r];
    end
  end

endmodule

// File: tb/tb_decode_issue_queue.sv
// tb_decode_issue_queue: directed self-checking bench for decode_issue_queue.
module tb_decode_issue_queue;
  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  decode_issue_queue_if bus();

  decode_issue_queue #(.XLEN(32), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
    bus.in_valid = 1'b1;
    bus.in_inst  = inst;
    bus.in_pc    = pc;
  endtask

  task automatic check_head(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                            input logic [31:0] imm, input logic [2:0] fmt, input logic ill);
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_inst"}, bus.out_inst, inst);
    check({tag, "_pc"}, bus.out_pc, pc);
    check({tag, "_imm"}, bus.out_imm, imm);
    check({tag, "_fmt"}, {29'd0, bus.out_fmt}, {29'd0, fmt});
    check({tag, "_ill"}, {31'd0, bus.out_illegal}, {31'd0, ill});
  endtask

  logic [31:0] s_inst [4];
  logic [31:0] s_imm  [4];
  logic [2:0]  s_fmt  [4];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_inst   = 32'd0;
    bus.in_pc     = 32'd0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;

    // Reset state
    #2;
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_out_inst", bus.out_inst, 32'd0);
    check("rst_out_imm", bus.out_imm, 32'd0);
    check("rst_out_fmt", {29'd0, bus.out_fmt}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // addi x1,x0,-1
    offer(32'hFFF00093, 32'h0000_0100);
    step();
    bus.in_valid = 1'b0;
    check_head("addi", 32'hFFF00093, 32'h100, 32'hFFFFFFFF, 3'd1, 1'b0);
    bus.out_ready = 1'b1;
    step();
    check("addi_pop", {31'd0, bus.out_valid}, 32'd0);

    // Streaming S/B/U/J with out_ready held high
    s_inst[0] = 32'hFE112E23; s_imm[0] = 32'hFFFFFFFC; s_fmt[0] = 3'd2;
    s_inst[1] = 32'hFE000CE3; s_imm[1] = 32'hFFFFFFF8; s_fmt[1] = 3'd3;
    s_inst[2] = 32'h123452B7; s_imm[2] = 32'h12345000; s_fmt[2] = 3'd4;
    s_inst[3] = 32'h001000EF; s_imm[3] = 32'h00000800; s_fmt[3] = 3'd5;
    for (int i = 0; i < 4; i++) begin
      offer(s_inst[i], 32'h200 + 32'(i * 4));
      step();
      check_head($sformatf("stream%0d", i), s_inst[i], 32'h200 + 32'(i * 4), s_imm[i], s_fmt[i], 1'b0);
      check($sformatf("stream%0d_rdy", i), {31'd0, bus.in_ready}, 32'd1);
    end
    bus.in_valid = 1'b0;
    step();
    check("stream_empty", {31'd0, bus.out_valid}, 32'd0);

    // Backpressure: three offered, two accepted, third held
    bus.out_ready = 1'b0;
    offer(32'h00100093, 32'h300);
    step();
    check("bp_rdy1", {31'd0, bus.in_ready}, 32'd1);
    offer(32'h00000033, 32'h304);
    step();
    check("bp_rdy_full", {31'd0, bus.in_ready}, 32'd0);
    check("bp_head_a", bus.out_inst, 32'h00100093);
    offer(32'h00002083, 32'h308);
    step();
    check("bp_still_full", {31'd0, bus.in_ready}, 32'd0);
    check("bp_stable_a", bus.out_inst, 32'h00100093);
    check("bp_stable_pc", bus.out_pc, 32'h300);
    bus.out_ready = 1'b1;
    step();
    check("bp_head_b", bus.out_inst, 32'h00000033);
    check("bp_pc_b", bus.out_pc, 32'h304);
    step();
    bus.in_valid = 1'b0;
    check("bp_head_c", bus.out_inst, 32'h00002083);
    check("bp_pc_c", bus.out_pc, 32'h308);
    step();
    check("bp_empty", {31'd0, bus.out_valid}, 32'd0);

    // Flush in state TWO with a same-cycle push
    bus.out_ready = 1'b0;
    offer(32'h00500113, 32'h400);
    step();
    offer(32'h00600193, 32'h404);
    step();
    check("fl_full", {31'd0, bus.in_ready}, 32'd0);
    bus.flush = 1'b1;
    offer(32'hDEADB037, 32'h408);
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("fl_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("fl_in_ready", {31'd0, bus.in_ready}, 32'd1);
    offer(32'h00700213, 32'h40C);
    step();
    bus.in_valid  = 1'b0;
    check_head("fl_next", 32'h00700213, 32'h40C, 32'h00000007, 3'd1, 1'b0);
    bus.out_ready = 1'b1;
    step();
    check("fl_dropped", {31'd0, bus.out_valid}, 32'd0);

    // Illegal, RV64-only, R-type and negative U-type immediates
    offer(32'h0000007F, 32'h500);
    step();
    check_head("ill7f", 32'h0000007F, 32'h500, 32'd0, 3'd7, 1'b1);
    offer(32'h0000001B, 32'h504);
    step();
    check_head("ill1b", 32'h0000001B, 32'h504, 32'd0, 3'd7, 1'b1);
    offer(32'h00000033, 32'h508);
    step();
    check_head("rtype", 32'h00000033, 32'h508, 32'd0, 3'd0, 1'b0);
    offer(32'h80000017, 32'h50C);
    step();
    bus.in_valid = 1'b0;
    check_head("auipc", 32'h80000017, 32'h50C, 32'h80000000, 3'd4, 1'b0);
    step();
    check("misc_empty", {31'd0, bus.out_valid}, 32'd0);

    // Asynchronous reset in state TWO
    bus.out_ready = 1'b0;
    offer(32'h00100093, 32'h600);
    step();
    offer(32'h00200093, 32'h604);
    step();
    bus.in_valid = 1'b0;
    check("ar_full", {31'd0, bus.in_ready}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("ar_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("ar_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("ar_out_inst", bus.out_inst, 32'd0);
    check("ar_out_pc", bus.out_pc, 32'd0);
    check("ar_out_imm", bus.out_imm, 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("ar_rel_ready", {31'd0, bus.in_ready}, 32'd1);
    offer(32'hFFC00113, 32'h700);
    step();
    bus.in_valid = 1'b0;
    check_head("ar_push", 32'hFFC00113, 32'h700, 32'hFFFFFFFC, 3'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
